// File: rtl/net_rx_deframer.sv
// net_rx_deframer: strips the SL3 header beat and forwards payload
// beats as PacketWords through a 2-entry skid buffer.
package net_rx_pkg;
  localparam int PW_DATA_WIDTH = 512;

  typedef struct packed {
    logic [31:0] metadata;
    logic [15:0] src_addr;
    logic [15:0] dest_addr;
  } pkt_hdr_t;

  typedef struct packed {
    logic                     valid;
    logic                     last;
    logic [PW_DATA_WIDTH-1:0] data;
    pkt_hdr_t                 header;
  } packet_word_t;
endpackage

module net_rx_deframer
  import net_rx_pkg::*;
#(
  parameter int DATA_WIDTH = PW_DATA_WIDTH,
  parameter int LEN_WIDTH  = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [DATA_WIDTH-1:0] in_data,
  input  logic                  in_valid,
  input  logic                  in_last,
  output logic                  in_ready,
  output packet_word_t          layer_rx,
  input  logic                  layer_rx_ready,
  output logic [7:0]            malformed_count,
  output logic [15:0]           packet_count
);

  typedef enum logic [1:0] {
    S_HDR,
    S_PAY,
    S_DROP
  } state_t;

  typedef struct packed {
    logic                  last;
    logic [DATA_WIDTH-1:0] data;
    pkt_hdr_t              header;
  } ent_t;

  state_t               state;
  ent_t                 ent [2];
  logic [1:0]           cnt;
  pkt_hdr_t             hdr_q;
  logic [LEN_WIDTH-1:0] rem;
  logic [LEN_WIDTH-1:0] bc;
  logic                 pop;
  logic                 push;
  logic                 acc;
  logic                 room;
  logic                 last_rem;
  logic                 wr_idx;
  logic                 malf_inc;
  logic                 pkt_inc;

  assign bc       = in_data[64 +: LEN_WIDTH];
  assign pop      = (cnt != 2'd0) & layer_rx_ready;
  assign room     = (cnt != 2'd2) | pop;
  assign acc      = in_valid & in_ready;
  assign push     = acc & (state == S_PAY);
  assign last_rem = (rem == LEN_WIDTH'(1));
  // Slot 1 is written only when slot 0 stays occupied this cycle.
  assign wr_idx   = (cnt == 2'd2) | ((cnt == 2'd1) & ~pop);

  always_comb begin
    in_ready = 1'b0;
    if (rst_n) begin
      unique case (1'b1)
        (state == S_PAY): in_ready = room;
        default:          in_ready = 1'b1;
      endcase
    end
  end

  always_comb begin
    malf_inc = 1'b0;
    pkt_inc  = 1'b0;
    unique case (1'b1)
      (state == S_HDR): malf_inc = acc & (in_last | (bc == '0));
      (state == S_PAY): begin
        pkt_inc  = acc & in_last & last_rem;
        malf_inc = acc & (in_last ^ last_rem);
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state           <= S_HDR;
      cnt             <= 2'd0;
      hdr_q           <= '0;
      rem             <= '0;
      malformed_count <= 8'd0;
      packet_count    <= 16'd0;
    end else begin
      if (pop) ent[0] <= ent[1];
      if (push) begin
        ent[wr_idx] <= '{last: in_last | last_rem,
                         data: in_data,
                         header: hdr_q};
      end
      cnt <= cnt + {1'b0, push} - {1'b0, pop};
      if (malf_inc && malformed_count != 8'hFF)
        malformed_count <= malformed_count + 8'd1;
      if (pkt_inc) packet_count <= packet_count + 16'd1;
      case (state)
        S_HDR: begin
          if (acc && !in_last) begin
            if (bc == '0) begin
              state <= S_DROP;
            end else begin
              hdr_q <= in_data[63:0];
              rem   <= bc;
              state <= S_PAY;
            end
          end
        end
        S_PAY: begin
          if (acc) begin
            rem <= rem - LEN_WIDTH'(1);
            if (in_last) state <= S_HDR;
            else if (last_rem) state <= S_DROP;
          end
        end
        S_DROP: begin
          if (acc && in_last) state <= S_HDR;
        end
        default: state <= S_HDR;
      endcase
    end
  end

  assign layer_rx = '{valid: cnt != 2'd0,
                      last: ent[0].last,
                      data: ent[0].data,
                      header: ent[0].header};

endmodule

// File: tb/tb_net_rx_deframer.sv
// Bench for net_rx_deframer: vector table, corner sequences and
// randomized traffic against a packet-level reference model.
module tb_net_rx_deframer;
  import net_rx_pkg::*;

  localparam int DW = 512;

  typedef logic [DW-1:0] word_q_t[$];

  typedef struct {
    logic [15:0]   dest;
    logic [15:0]   src;
    logic [31:0]   meta;
    logic [DW-1:0] data;
    logic          last;
  } exp_t;

  typedef struct {
    logic [15:0] d;
    logic [15:0] s;
    logic [31:0] m;
    int          bc;
    int          npay;
    int          nout;
    int          dmal;
    int          dpkt;
  } vec_t;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [DW-1:0] in_data;
  logic          in_valid;
  logic          in_last;
  logic          in_ready;
  packet_word_t  layer_rx;
  logic          layer_rx_ready;
  logic [7:0]    malformed_count;
  logic [15:0]   packet_count;

  net_rx_deframer dut (
    .clk(clk),
    .rst_n(rst_n),
    .in_data(in_data),
    .in_valid(in_valid),
    .in_last(in_last),
    .in_ready(in_ready),
    .layer_rx(layer_rx),
    .layer_rx_ready(layer_rx_ready),
    .malformed_count(malformed_count),
    .packet_count(packet_count)
  );

  always #5 clk = ~clk;

  exp_t         expq[$];
  int           out_cyc[$];
  int           n_tests = 0;
  int           n_fail = 0;
  int           exp_mal = 0;
  int           exp_pkt = 0;
  int           n_out = 0;
  int           cyc = 0;
  bit           rnd_ready = 1'b0;
  bit           ready_force = 1'b0;
  logic         stall_q = 1'b0;
  packet_word_t prev_w;
  exp_t         e;

  task automatic chk(string name, logic [639:0] act, logic [639:0] want);
    n_tests++;
    if (act !== want) begin
      n_fail++;
      $display("FAIL %s: got %0h want %0h", name, act, want);
    end
  endtask

  always @(posedge clk) cyc++;

  initial begin
    layer_rx_ready = 1'b0;
    forever begin
      @(posedge clk);
      #2;
      layer_rx_ready = rnd_ready ? ($urandom_range(3) != 0) : ready_force;
    end
  end

  // Output monitor: every handshake must match the model queue head
  always @(negedge clk) begin
    if (!rst_n) begin
      stall_q <= 1'b0;
    end else begin
      if (stall_q) chk("hold_stable", layer_rx, prev_w);
      if (layer_rx.valid && layer_rx_ready) begin
        n_out++;
        out_cyc.push_back(cyc);
        if (expq.size() == 0) begin
          chk("unexpected_beat", 1, 0);
        end else begin
          e = expq.pop_front();
          chk("out_dest", layer_rx.header.dest_addr, e.dest);
          chk("out_src", layer_rx.header.src_addr, e.src);
          chk("out_meta", layer_rx.header.metadata, e.meta);
          chk("out_data", layer_rx.data, e.data);
          chk("out_last", layer_rx.last, e.last);
        end
      end
      stall_q <= layer_rx.valid && !layer_rx_ready;
      prev_w  <= layer_rx;
    end
  end

  function automatic logic [DW-1:0] rand_word();
    logic [DW-1:0] w;
    for (int i = 0; i < DW / 32; i++) w[i*32 +: 32] = $urandom;
    return w;
  endfunction

  function automatic logic [DW-1:0] mk_hdr(logic [15:0] d, logic [15:0] s,
                                           logic [31:0] m, int bc);
    logic [DW-1:0] h;
    h = rand_word();
    h[15:0]  = d;
    h[31:16] = s;
    h[63:32] = m;
    h[79:64] = 16'(bc);
    return h;
  endfunction

  function automatic void bump_mal();
    if (exp_mal < 255) exp_mal++;
  endfunction

  // Packet-level model: a packet is everything up to in_last
  task automatic build_pkt(input logic [15:0] d, input logic [15:0] s,
                           input logic [31:0] m, input int bc,
                           input int npay, output word_q_t beats);
    logic [DW-1:0] pay[$];
    int nfwd;
    beats = {};
    for (int i = 0; i < npay; i++) pay.push_back(rand_word());
    if (npay == 0 || bc == 0) begin
      bump_mal();
    end else begin
      nfwd = (npay < bc) ? npay : bc;
      for (int i = 0; i < nfwd; i++)
        expq.push_back('{dest: d, src: s, meta: m, data: pay[i],
                         last: (i == nfwd - 1)});
      if (npay == bc) exp_pkt = (exp_pkt + 1) % 65536;
      else bump_mal();
    end
    beats.push_back(mk_hdr(d, s, m, bc));
    foreach (pay[i]) beats.push_back(pay[i]);
  endtask

  task automatic send_beat(input logic [DW-1:0] data, input logic last,
                           input int gapmax);
    int k;
    logic acc;
    repeat ($urandom_range(gapmax)) begin
      in_valid = 1'b0;
      @(posedge clk);
      #1;
    end
    in_valid = 1'b1;
    in_data  = data;
    in_last  = last;
    k = 0;
    do begin
      @(negedge clk);
      acc = in_ready;
      @(posedge clk);
      #1;
      k++;
    end while (!acc && k < 200);
    if (!acc) chk("accept_timeout", 0, 1);
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic send_pkt(input logic [15:0] d, input logic [15:0] s,
                          input logic [31:0] m, input int bc,
                          input int npay, input int gapmax);
    word_q_t b;
    build_pkt(d, s, m, bc, npay, b);
    foreach (b[i]) send_beat(b[i], (i == b.size() - 1), gapmax);
  endtask

  task automatic drain();
    int k;
    k = 0;
    while ((expq.size() != 0 || layer_rx.valid) && k < 1000) begin
      @(posedge clk);
      k++;
    end
    #1;
    if (k >= 1000) chk("drain_timeout", 0, 1);
    repeat (2) @(posedge clk);
    #1;
  endtask

  initial begin
    vec_t    tv[7];
    word_q_t qa;
    word_q_t qb;
    logic [DW-1:0] seq[6];
    bit      lastv[6];
    bit      exp_rdy[5];
    int      n0;
    int      m0;
    int      p0;

    tv[0] = '{16'h3, 16'h7, 32'hA5, 4, 4, 4, 0, 1};
    tv[1] = '{16'h11, 16'h22, 32'h33, 3, 2, 2, 1, 0};
    tv[2] = '{16'h44, 16'h55, 32'h66, 2, 5, 2, 1, 0};
    tv[3] = '{16'h1, 16'h2, 32'h3, 4, 0, 0, 1, 0};
    tv[4] = '{16'h5, 16'h6, 32'h7, 0, 2, 0, 1, 0};
    tv[5] = '{16'h9, 16'h8, 32'hDEADBEEF, 1, 1, 1, 0, 1};
    tv[6] = '{16'hFFFF, 16'h0, 32'h12345678, 5, 5, 5, 0, 1};

    rst_n    = 1'b0;
    in_valid = 1'b0;
    in_last  = 1'b0;
    in_data  = '0;
    ready_force = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    @(negedge clk);
    chk("rst_valid", layer_rx.valid, 0);
    chk("rst_in_ready", in_ready, 0);
    chk("rst_malformed", malformed_count, 0);
    chk("rst_packets", packet_count, 0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(negedge clk);
    chk("idle_in_ready", in_ready, 1);
    @(posedge clk);
    #1;

    for (int i = 0; i < 7; i++) begin
      n0 = n_out;
      m0 = exp_mal;
      p0 = exp_pkt;
      out_cyc = {};
      send_pkt(tv[i].d, tv[i].s, tv[i].m, tv[i].bc, tv[i].npay, 0);
      drain();
      chk("vec_nout", n_out - n0, tv[i].nout);
      chk("vec_malformed", malformed_count, m0 + tv[i].dmal);
      chk("vec_packets", packet_count, p0 + tv[i].dpkt);
      if (i == 0) begin
        for (int j = 1; j < 4; j++)
          chk("t1_consecutive", out_cyc[j] - out_cyc[j-1], 1);
      end
    end

    // Backpressure: two 2-beat packets against a stalled sink
    n0 = n_out;
    p0 = exp_pkt;
    build_pkt(16'hA00, 16'hA01, 32'hA02, 2, 2, qa);
    build_pkt(16'hB00, 16'hB01, 32'hB02, 2, 2, qb);
    for (int k = 0; k < 3; k++) begin
      seq[k]     = qa[k];
      seq[k+3]   = qb[k];
      lastv[k]   = (k == 2);
      lastv[k+3] = (k == 2);
    end
    exp_rdy = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
    ready_force = 1'b0;
    @(posedge clk);
    #1;
    for (int k = 0; k < 5; k++) begin
      in_valid = 1'b1;
      in_data  = seq[k];
      in_last  = lastv[k];
      @(negedge clk);
      chk("t2_in_ready", in_ready, exp_rdy[k]);
      @(posedge clk);
      #1;
    end
    ready_force = 1'b1;
    send_beat(seq[4], lastv[4], 0);
    send_beat(seq[5], lastv[5], 0);
    drain();
    chk("t2_nout", n_out - n0, 4);
    chk("t2_packets", packet_count, p0 + 2);

    // Randomized traffic with random gaps and sink stalls
    rnd_ready = 1'b1;
    for (int i = 0; i < 60; i++) begin
      send_pkt(16'($urandom), 16'($urandom), $urandom,
               $urandom_range(6), $urandom_range(8), 2);
    end
    drain();
    chk("rand_malformed", malformed_count, exp_mal);
    chk("rand_packets", packet_count, exp_pkt);
    chk("rand_queue_empty", expq.size(), 0);

    // Saturation, then reset in the middle of a packet
    rnd_ready = 1'b0;
    ready_force = 1'b1;
    for (int i = 0; i < 300; i++)
      send_pkt(16'($urandom), 16'($urandom), $urandom,
               $urandom_range(3, 1), 0, 0);
    drain();
    chk("sat_malformed", malformed_count, 255);
    chk("sat_model", malformed_count, exp_mal);

    ready_force = 1'b0;
    @(posedge clk);
    #1;
    send_beat(mk_hdr(16'h77, 16'h88, 32'h99, 4), 1'b0, 0);
    send_beat(rand_word(), 1'b0, 0);
    @(negedge clk);
    chk("mid_valid", layer_rx.valid, 1);
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    @(negedge clk);
    chk("mid_rst_in_ready", in_ready, 0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    exp_mal = 0;
    exp_pkt = 0;
    @(negedge clk);
    chk("post_rst_valid", layer_rx.valid, 0);
    chk("post_rst_malformed", malformed_count, 0);
    chk("post_rst_packets", packet_count, 0);
    @(posedge clk);
    #1;
    ready_force = 1'b1;
    n0 = n_out;
    send_pkt(16'h0A, 16'h0B, 32'hC0FFEE, 1, 1, 0);
    drain();
    chk("post_rst_nout", n_out - n0, 1);
    chk("post_rst_pkt", packet_count, 1);
    chk("post_rst_mal", malformed_count, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
